f2_eval_pipe: RTL and testbench
===============================

F2_EVAL_PIPE -- requirements
Module: f2_eval_pipe

Interface
REQ-001 SHALL have parameter NCH, default 4: number of parallel evaluation lanes (1..32).
REQ-002 SHALL have parameter CNT_W, default 16: width of the ones-count accumulator.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports b, d, g, f, e  in  NCH each  per-lane function inputs.
REQ-006 SHALL have ports in_valid in 1 and in_ready out 1: input handshake.
REQ-007 SHALL have port mode  in  2  0=F2 form, 1=F2_MIN form, 2=CHECK (lane bit = form disagreement), 3=reserved (acts as 0).
REQ-008 SHALL have ports out_valid out 1, out_ready in 1, out_f out NCH: result handshake and per-lane result.
REQ-009 SHALL have ports ones_cnt out CNT_W, mismatch_sticky out 1, clr_stats in 1.
REQ-010 SHALL have ports st_start in 1, st_busy out 1, st_done out 1, st_pass out 1 (self-test; present only with F2_SELFTEST_EN).

Function
REQ-011 Lane function SHALL be f = g & (b ? (d|e) : (~d|f)); F2 form = g & ((b&(d|e)) | (~b&(~d|f))); F2_MIN form = g & ((d&(b|f)) | (~d&(~b|e))).
REQ-012 Pipeline SHALL be two register stages (S1: operands + mode; S2: results); accept-to-out_valid latency exactly 2 cycles when out_ready held high.
REQ-013 A stage SHALL advance when it is empty or its downstream consumer takes it; in_ready = S1 empty or S1 advancing; full throughput 1 beat/cycle.
REQ-014 out_valid SHALL hold and out_f SHALL be stable while out_ready is low; no beat dropped or duplicated.
REQ-015 mode SHALL be sampled with the beat into S1; changing mode never alters beats already in flight.
REQ-016 On each output handshake ones_cnt SHALL add popcount(out_f), saturating at 2^CNT_W-1.
REQ-017 In CHECK mode, any set out_f bit on handshake SHALL set mismatch_sticky; only clr_stats or reset clears it.
REQ-018 clr_stats SHALL zero ones_cnt and mismatch_sticky next cycle; same-cycle handshake is not counted (clear wins).

Reset
REQ-019 On rst_n low, immediately: S1/S2 empty, out_valid=0, out_f=0, in_ready=0 while asserted, ones_cnt=0, mismatch_sticky=0, st_busy=0, st_done=0, st_pass=0, FSM=IDLE.
REQ-020 in_ready SHALL be 1 on the first clock edge after deassertion.
REQ-021 Reset mid-self-test SHALL abort the sweep with no pass reported.

Configuration
REQ-022 Macro F2_SELFTEST_EN SHALL compile in self-test FSM IDLE->WAIT_DRAIN->SWEEP->DONE.
REQ-023 IDLE: st_start high -> WAIT_DRAIN; WAIT_DRAIN: in_ready=0 until S1 and S2 empty -> SWEEP.
REQ-024 SWEEP: 5-bit index i = {b,d,g,f,e} runs 0..31, one per cycle (32 cycles); compare F2, F2_MIN and bit i of F2_TT; any miss clears pass flag.
REQ-025 DONE: st_done=1, st_pass valid, in_ready restored; st_start in DONE -> WAIT_DRAIN (rerun); st_start ignored in other states; st_busy=1 in WAIT_DRAIN/SWEEP.
REQ-026 Without macro: st_* ports absent, FSM absent, in_ready depends only on pipeline.

Structure
REQ-027 Package f2_pkg SHALL hold mode_e enum, st_state_e enum, lane-operand struct, constant F2_TT = 32'hF0A0_C0F0.
REQ-028 Sub-module f2_lane (combinational, one lane, both forms) SHALL be instantiated NCH times plus once for self-test.

Verification
REQ-029 Reset, then b=1,d=0,g=1,f=0,e=1 on all lanes, mode 0 -> out_f=all-ones 2 cycles later, ones_cnt=NCH.
REQ-030 Exhaustive 32 vectors per lane, modes 0 and 1 -> out_f matches F2_TT bit; mode 2 -> out_f=0, mismatch_sticky stays 0.
REQ-031 out_ready low 5 cycles with 3 beats offered -> in_ready drops after 2 held; release -> 3 beats in order, none lost.
REQ-032 CNT_W=4, NCH=4, 5 all-ones beats -> ones_cnt saturates at 15; clr_stats with a handshake -> ones_cnt=0.
REQ-033 F2_SELFTEST_EN: st_start with 2 beats in flight -> drain, 32-cycle sweep, st_done=1, st_pass=1; rst_n low at sweep cycle 10 -> st_busy=0, st_pass=0.

Source files
------------

// File: rtl/f2_pkg.sv
// f2_pkg -- shared types and constants for the F2 evaluation pipeline.
//   mode_e      : per-beat evaluation mode (F2, F2_MIN, CHECK, reserved = F2)
//   st_state_e  : self-test FSM states
//   lane_ops_t  : one lane's operands; packed so that {b,d,g,f,e} is the
//                 5-bit truth-table index used by the self-test sweep
//   F2_TT       : truth table of the lane function, bit i = f(i)
package f2_pkg;

  typedef enum logic [1:0] {
    MODE_F2     = 2'd0,
    MODE_F2_MIN = 2'd1,
    MODE_CHECK  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_DRAIN = 2'd1,
    ST_SWEEP      = 2'd2,
    ST_DONE       = 2'd3
  } st_state_e;

  typedef struct packed {
    logic b;
    logic d;
    logic g;
    logic f;
    logic e;
  } lane_ops_t;

  localparam logic [31:0] F2_TT = 32'hF0A0_C0F0;

endpackage

// File: rtl/f2_lane.sv
// f2_lane -- one combinational evaluation lane producing both algebraic
// forms of f = g & (b ? (d|e) : (~d|f)).
//   ops    : lane operands {b,d,g,f,e}
//   f2     : sum-of-products form split on b
//   f2_min : minimised form split on d
// The two forms are logically equal; CHECK mode exposes any disagreement.
module f2_lane
  import f2_pkg::*;
(
  input  lane_ops_t ops,
  output logic      f2,
  output logic      f2_min
);

  assign f2     = ops.g & ((ops.b & (ops.d | ops.e)) | (~ops.b & (~ops.d | ops.f)));
  assign f2_min = ops.g & ((ops.d & (ops.b | ops.f)) | (~ops.d & (~ops.b | ops.e)));

endmodule

// File: rtl/f2_eval_pipe.sv
// f2_eval_pipe -- NCH-lane, two-stage valid/ready pipeline evaluating the F2
// lane function, with output statistics and an optional built-in self-test.
//   clk, rst_n          : clock, asynchronous active-low reset
//   b, d, g, f, e       : per-lane operands (NCH bits each)
//   in_valid / in_ready : input handshake; mode is captured with the beat
//   mode                : 0=F2, 1=F2_MIN, 2=CHECK (form disagreement), 3=F2
//   out_valid/out_ready : result handshake, out_f = per-lane result
//   ones_cnt            : saturating count of result ones over handshakes
//   mismatch_sticky     : set by any non-zero CHECK result; cleared by clr_stats
//   clr_stats           : zero the statistics (wins over a same-cycle handshake)
//   st_start/st_busy/st_done/st_pass : self-test control and status, present
//                         only when F2_SELFTEST_EN is defined
module f2_eval_pipe
  import f2_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   b,
  input  logic [NCH-1:0]   d,
  input  logic [NCH-1:0]   g,
  input  logic [NCH-1:0]   f,
  input  logic [NCH-1:0]   e,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NCH-1:0]   out_f,
  output logic [CNT_W-1:0] ones_cnt,
  output logic             mismatch_sticky,
  input  logic             clr_stats
`ifdef F2_SELFTEST_EN
  ,
  input  logic             st_start,
  output logic             st_busy,
  output logic             st_done,
  output logic             st_pass
`endif
);

  localparam int SUM_W = CNT_W + 6;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic           run_q;
  logic           s1_valid, s2_valid, s2_check;
  logic [NCH-1:0] s1_b, s1_d, s1_g, s1_f, s1_e;
  mode_e          s1_mode;
  logic           s1_ready, s2_ready, in_fire, out_fire, in_open;
  logic [NCH-1:0] lane_f2, lane_min, lane_res;
  logic [SUM_W-1:0] cnt_sum;

  // A stage can take new data when empty or when its contents leave this cycle.
  assign s2_ready  = !s2_valid || out_ready;
  assign s1_ready  = !s1_valid || s2_ready;
  assign in_ready  = run_q && in_open && s1_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign out_fire  = s2_valid && out_ready;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    lane_ops_t lane_ops;
    assign lane_ops = '{b: s1_b[i], d: s1_d[i], g: s1_g[i], f: s1_f[i], e: s1_e[i]};
    f2_lane u_lane (.ops(lane_ops), .f2(lane_f2[i]), .f2_min(lane_min[i]));
  end

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    lane_res = lane_f2;
    case (s1_mode)
      MODE_F2_MIN: lane_res = lane_min;
      MODE_CHECK:  lane_res = lane_f2 ^ lane_min;
      default:     lane_res = lane_f2;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_check <= 1'b0;
      out_f    <= '0;
    end else begin
      run_q <= 1'b1;  // holds in_ready low until the first edge after reset
      if (s1_ready) s1_valid <= in_fire;
      if (s2_ready) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_f    <= lane_res;
          s2_check <= (s1_mode == MODE_CHECK);
        end
      end
    end
  end

  // NOTE: operand/mode payload registers carry no reset; s1_valid qualifies them, so reset only the control bits.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_b    <= b;
      s1_d    <= d;
      s1_g    <= g;
      s1_f    <= f;
      s1_e    <= e;
      s1_mode <= mode_e'(mode);
    end
  end

  assign cnt_sum = SUM_W'(ones_cnt) + SUM_W'($countones(out_f));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_cnt        <= '0;
      mismatch_sticky <= 1'b0;
    end else if (clr_stats) begin
      ones_cnt        <= '0;
      mismatch_sticky <= 1'b0;
    end else if (out_fire) begin
      ones_cnt <= (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
      if (s2_check && (|out_f)) mismatch_sticky <= 1'b1;
    end
  end

`ifdef F2_SELFTEST_EN
  st_state_e st_state;
  logic [4:0] st_idx;
  logic       st_acc, st_f2, st_min, st_miss;
  lane_ops_t  st_ops;

  // The sweep index doubles as the lane operands, so index i evaluates f(i).
  assign st_ops  = lane_ops_t'(st_idx);
  assign st_miss = (st_f2 != F2_TT[st_idx]) || (st_min != F2_TT[st_idx]);
  assign in_open = (st_state == ST_IDLE) || (st_state == ST_DONE);

  f2_lane u_st_lane (.ops(st_ops), .f2(st_f2), .f2_min(st_min));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_state <= ST_IDLE;
      st_idx   <= '0;
      st_acc   <= 1'b0;
      st_busy  <= 1'b0;
      st_done  <= 1'b0;
      st_pass  <= 1'b0;
    end else begin
      case (st_state)
        ST_IDLE, ST_DONE: begin
          if (st_start) begin
            st_state <= ST_WAIT_DRAIN;
            st_busy  <= 1'b1;
            st_done  <= 1'b0;
            st_pass  <= 1'b0;
          end
        end
        ST_WAIT_DRAIN: begin
          if (!s1_valid && !s2_valid) begin
            st_state <= ST_SWEEP;
            st_idx   <= '0;
            st_acc   <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (st_miss) st_acc <= 1'b0;
          if (st_idx == 5'd31) begin
            st_state <= ST_DONE;
            st_busy  <= 1'b0;
            st_done  <= 1'b1;
            st_pass  <= st_acc & ~st_miss;
          end else begin
            st_idx <= st_idx + 5'd1;
          end
        end
        default: st_state <= ST_IDLE;
      endcase
    end
  end
`else
  assign in_open = 1'b1;
`endif

endmodule

// File: tb/tb_f2_eval_pipe.sv
// tb_f2_eval_pipe -- self-checking bench for f2_eval_pipe (NCH=4, CNT_W=16)
// with a second NCH=4, CNT_W=4 instance sharing the stimulus for saturation.
// Self-test sequences are included when F2_SELFTEST_EN is defined.
module tb_f2_eval_pipe;

  localparam int NCH   = 4;
  localparam int CNT_W = 16;

  typedef struct {
    logic [NCH-1:0] f;
    logic           chk;
  } exp_t;

  typedef struct {
    logic [4:0]     idx;
    logic [1:0]     m;
    logic [NCH-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NCH-1:0]   b, d, g, f, e;
  logic             in_valid, in_ready, out_valid, out_ready, clr_stats;
  logic [1:0]       mode;
  logic [NCH-1:0]   out_f;
  logic [CNT_W-1:0] ones_cnt;
  logic             sticky;
  logic             in_ready_s, out_valid_s, sticky_s;
  logic [NCH-1:0]   out_f_s;
  logic [3:0]       ones_cnt_s;
`ifdef F2_SELFTEST_EN
  logic st_start, st_busy, st_done, st_pass;
  logic st_busy_s, st_done_s, st_pass_s;
`endif

  f2_eval_pipe #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .b(b), .d(d), .g(g), .f(f), .e(e),
    .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f),
    .ones_cnt(ones_cnt), .mismatch_sticky(sticky), .clr_stats(clr_stats)
`ifdef F2_SELFTEST_EN
    , .st_start(st_start), .st_busy(st_busy), .st_done(st_done), .st_pass(st_pass)
`endif
  );

  f2_eval_pipe #(.NCH(NCH), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .b(b), .d(d), .g(g), .f(f), .e(e),
    .in_valid(in_valid), .in_ready(in_ready_s), .mode(mode),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_f(out_f_s),
    .ones_cnt(ones_cnt_s), .mismatch_sticky(sticky_s), .clr_stats(clr_stats)
`ifdef F2_SELFTEST_EN
    , .st_start(1'b0), .st_busy(st_busy_s), .st_done(st_done_s), .st_pass(st_pass_s)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  exp_t        exp_q[$];
  int unsigned m_cnt, m_cnt_s;
  logic        m_sticky;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the lane rule and its minimised form, evaluated lane by lane.
  function automatic logic [NCH-1:0] ref_f(input logic [NCH-1:0] vb, vd, vg, vf, ve,
                                           input logic [1:0] vm);
    logic [NCH-1:0] r2, rmin;
    for (int i = 0; i < NCH; i++) begin
      r2[i]   = vg[i] && (vb[i] ? (vd[i] || ve[i]) : (!vd[i] || vf[i]));
      rmin[i] = vg[i] && (vd[i] ? (vb[i] || vf[i]) : (!vb[i] || ve[i]));
    end
    if (vm == 2'd2) return r2 ^ rmin;
    if (vm == 2'd1) return rmin;
    return r2;
  endfunction

  // One cycle, entered and left at a falling edge.
  task automatic step(input logic iv, input logic [NCH-1:0] vb, vd, vg, vf, ve,
                      input logic [1:0] vm, input logic ordy, input logic clr,
                      input logic [NCH-1:0] exp_f, output logic acc);
    exp_t        head;
    int unsigned pc;
    b = vb; d = vd; g = vg; f = vf; e = ve;
    in_valid = iv; mode = vm; out_ready = ordy; clr_stats = clr;
    #1;
    acc = iv && in_ready;
    pc  = 0;
    head.f = '0; head.chk = 1'b0;
    if (out_valid) begin
      if (exp_q.size() == 0) check("out_valid_when_empty", out_valid, 1'b0);
      else begin
        head = exp_q[0];
        check("out_f", out_f, head.f);
        if (ordy) begin
          void'(exp_q.pop_front());
          pc = $countones(head.f);
        end
      end
    end
    if (clr) begin
      m_cnt = 0; m_cnt_s = 0; m_sticky = 1'b0;
    end else if (out_valid && ordy) begin
      m_cnt   = (m_cnt + pc > 65535) ? 65535 : m_cnt + pc;
      m_cnt_s = (m_cnt_s + pc > 15) ? 15 : m_cnt_s + pc;
      if (head.chk && head.f != '0) m_sticky = 1'b1;
    end
    if (acc) exp_q.push_back('{f: exp_f, chk: (vm == 2'd2)});
    @(negedge clk);
    check("ones_cnt", ones_cnt, m_cnt);
    check("ones_cnt_w4", ones_cnt_s, m_cnt_s);
    check("mismatch_sticky", sticky, m_sticky);
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step(1'b0, '0, '0, '0, '0, '0, 2'd0, ordy, 1'b0, '0, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1'b1);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_f", out_f, '0);
    check("rst_ones_cnt", ones_cnt, 0);
    check("rst_sticky", sticky, 1'b0);
`ifdef F2_SELFTEST_EN
    check("rst_st_busy", st_busy, 1'b0);
    check("rst_st_done", st_done, 1'b0);
    check("rst_st_pass", st_pass, 1'b0);
`endif
    exp_q.delete();
    m_cnt = 0; m_cnt_s = 0; m_sticky = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready_held", in_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("in_ready_after_rst", in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t           tbl[96];
    logic [31:0]    tt;
    logic           acc;
    logic [5*NCH-1:0] beat[3];
    logic [NCH-1:0] vb, vd, vg, vf, ve;
    logic [1:0]     vm;
    int             k, n;

    b = '0; d = '0; g = '0; f = '0; e = '0; mode = 2'd0;
    in_valid = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
`ifdef F2_SELFTEST_EN
    st_start = 1'b0;
`endif
    apply_reset();
    @(negedge clk);

    // Single all-ones beat: visible two edges after acceptance.
    step(1'b1, '1, '0, '1, '0, '1, 2'd0, 1'b1, 1'b0, ref_f('1, '0, '1, '0, '1, 2'd0), acc);
    check("first_accept", acc, 1'b1);
    check("latency_1", out_valid, 1'b0);
    idle(1'b0);
    check("latency_2", out_valid, 1'b1);
    check("first_out_f", out_f, {NCH{1'b1}});
    idle(1'b1);
    check("first_ones_cnt", ones_cnt, NCH);

    // Exhaustive truth table on all lanes, modes 0/1/2, full throughput.
    tt = 32'hF0A0_C0F0;
    for (int i = 0; i < 32; i++)
      for (int mm = 0; mm < 3; mm++) begin
        tbl[i*3+mm].idx = i[4:0];
        tbl[i*3+mm].m   = mm[1:0];
        tbl[i*3+mm].exp = (mm == 2) ? '0 : {NCH{tt[i]}};
      end
    for (int i = 0; i < 96; i++) begin
      step(1'b1, {NCH{tbl[i].idx[4]}}, {NCH{tbl[i].idx[3]}}, {NCH{tbl[i].idx[2]}},
           {NCH{tbl[i].idx[1]}}, {NCH{tbl[i].idx[0]}}, tbl[i].m, 1'b1, 1'b0, tbl[i].exp, acc);
      check("tbl_accept", acc, 1'b1);
    end
    drain();
    check("tbl_sticky_clear", sticky, 1'b0);

    // Backpressure: 3 beats offered with out_ready low for 5 cycles.
    for (int i = 0; i < 3; i++) beat[i] = 20'($urandom);
    k = 0;
    for (int c = 0; c < 5; c++) begin
      {vb, vd, vg, vf, ve} = beat[k];
      vm = 2'(k % 2);
      step(1'b1, vb, vd, vg, vf, ve, vm, 1'b0, 1'b0, ref_f(vb, vd, vg, vf, ve, vm), acc);
      if (acc) k++;
    end
    check("bp_held_beats", k, 2);
    check("bp_in_ready_low", in_ready, 1'b0);
    for (int c = 0; c < 10 && (k < 3 || exp_q.size() != 0); c++) begin
      {vb, vd, vg, vf, ve} = beat[k < 3 ? k : 2];
      vm = 2'(k % 2);
      step(k < 3, vb, vd, vg, vf, ve, vm, 1'b1, 1'b0, ref_f(vb, vd, vg, vf, ve, vm), acc);
      if (acc) k++;
    end
    check("bp_all_accepted", k, 3);
    check("bp_all_delivered", exp_q.size(), 0);

    // Saturation of the 4-bit counter, then clear racing a handshake.
    step(1'b0, '0, '0, '0, '0, '0, 2'd0, 1'b1, 1'b1, '0, acc);
    for (int i = 0; i < 5; i++)
      step(1'b1, '0, '0, '1, '0, '0, 2'd0, 1'b1, 1'b0, ref_f('0, '0, '1, '0, '0, 2'd0), acc);
    drain();
    check("sat_w4_15", ones_cnt_s, 15);
    check("sat_w16_20", ones_cnt, 20);
    step(1'b1, '1, '1, '1, '1, '1, 2'd0, 1'b0, 1'b0, ref_f('1, '1, '1, '1, '1, 2'd0), acc);
    idle(1'b0);
    check("clr_pre_valid", out_valid, 1'b1);
    step(1'b0, '0, '0, '0, '0, '0, 2'd0, 1'b1, 1'b1, '0, acc);
    check("clr_wins_cnt", ones_cnt, 0);
    check("clr_wins_cnt_w4", ones_cnt_s, 0);
    check("clr_hs_done", exp_q.size(), 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      vb = NCH'($urandom); vd = NCH'($urandom); vg = NCH'($urandom);
      vf = NCH'($urandom); ve = NCH'($urandom); vm = 2'($urandom);
      step($urandom_range(0, 3) != 0, vb, vd, vg, vf, ve, vm, $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0, ref_f(vb, vd, vg, vf, ve, vm), acc);
    end
    drain();

    // Asynchronous reset mid-traffic.
    step(1'b1, '1, '0, '1, '0, '1, 2'd0, 1'b1, 1'b0, ref_f('1, '0, '1, '0, '1, 2'd0), acc);
    step(1'b1, '1, '0, '1, '0, '1, 2'd0, 1'b0, 1'b0, ref_f('1, '0, '1, '0, '1, 2'd0), acc);
    #2;
    apply_reset();
    @(negedge clk);

`ifdef F2_SELFTEST_EN
    // Self-test with two beats in flight: drain, sweep, pass.
    step(1'b1, '1, '0, '1, '0, '1, 2'd0, 1'b1, 1'b0, ref_f('1, '0, '1, '0, '1, 2'd0), acc);
    step(1'b1, '0, '1, '1, '1, '0, 2'd1, 1'b1, 1'b0, ref_f('0, '1, '1, '1, '0, 2'd1), acc);
    st_start = 1'b1;
    idle(1'b1);
    st_start = 1'b0;
    check("st_busy_start", st_busy, 1'b1);
    n = 0;
    while (!st_done && n < 80) begin
      #1;
      if (st_busy) check("st_in_ready_blocked", in_ready, 1'b0);
      idle(1'b1);
      n++;
    end
    check("st_done", st_done, 1'b1);
    check("st_pass", st_pass, 1'b1);
    check("st_busy_after", st_busy, 1'b0);
    check("st_sweep_len", (n >= 32 && n <= 36), 1'b1);
    check("st_drained", exp_q.size(), 0);
    #1;
    check("st_in_ready_restored", in_ready, 1'b1);

    // Rerun from DONE, then reset around sweep cycle 10.
    st_start = 1'b1;
    idle(1'b1);
    st_start = 1'b0;
    check("st_rerun_busy", st_busy, 1'b1);
    check("st_rerun_done_clr", st_done, 1'b0);
    repeat (11) idle(1'b1);
    #2;
    apply_reset();
    repeat (40) idle(1'b1);
    check("st_abort_done", st_done, 1'b0);
    check("st_abort_pass", st_pass, 1'b0);
    check("st_abort_busy", st_busy, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
